// File: rtl/memory_port_ctrl_pkg.sv
// Shared definitions for the coprocessor block-memory port: state encoding,
// default geometry of the memory block and the size of the protected region.
package memory_port_ctrl_pkg;

  // Geometry defaults, shared with the memory block itself
  localparam int MEM_SIZE       = 1024;
  localparam int MEM_BLOCKS     = 4;
  localparam int MEM_LOG_SIZE   = 10;
  localparam int MEM_CELL_WIDTH = 32;

  // Cells 0 and 1 hold the config and status words; block writes may not touch them
  localparam int PROTECTED_CELLS = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RD_ISSUE   = 2'd1,
    RD_CAPTURE = 2'd2,
    WR_ISSUE   = 2'd3
  } state_t;

endpackage

// File: rtl/memory_port_ctrl.sv
// Initiator side of the block memory port. Accepts one block read or write at
// a time from the core, drives the memory pins with registered strobes,
// captures registered read data one cycle after the read strobe and returns a
// one-cycle response. Status-word updates are forwarded independently.
module memory_port_ctrl
  import memory_port_ctrl_pkg::*;
#(
  parameter int size       = MEM_SIZE,
  parameter int blocks     = MEM_BLOCKS,
  parameter int log_size   = MEM_LOG_SIZE,
  parameter int cell_width = MEM_CELL_WIDTH,
  parameter int width      = blocks * cell_width
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  // core request channel
  input  logic                  in_req_valid,
  output logic                  out_req_ready,
  input  logic                  in_req_write,
  input  logic [log_size-1:0]   in_req_address,
  input  logic [width-1:0]      in_req_data,
  // core response channel
  output logic                  out_rsp_valid,
  output logic [width-1:0]      out_rsp_data,
  output logic                  out_rsp_error,
  // status update from the core
  input  logic [cell_width-1:0] in_status,
  input  logic                  in_status_we,
  // memory pins
  output logic [log_size-1:0]   out_mem_address,
  output logic [width-1:0]      out_mem_data,
  output logic                  out_mem_read_en,
  output logic                  out_mem_write_en,
  output logic [cell_width-1:0] out_mem_status,
  output logic                  out_mem_write_status_en,
  input  logic [width-1:0]      in_mem_data
);

  // One extra bit so address + blocks never wraps
  localparam logic [log_size:0] SIZE_EXT   = (log_size + 1)'(size);
  localparam logic [log_size:0] BLOCKS_EXT = (log_size + 1)'(blocks);
  localparam logic [log_size:0] PROT_EXT   = (log_size + 1)'(PROTECTED_CELLS);

  state_t            state;
  state_t            next_state;

  logic [log_size:0] end_addr;
  logic              range_err;
  logic              prot_err;
  logic              req_err;

  logic              accept;
  logic              load_req;
  logic              capture;
  logic              read_en_d;
  logic              write_en_d;
  logic              rsp_valid_d;
  logic              rsp_error_d;

  assign out_req_ready = (state == IDLE);

  // Range and write-protection check on the request currently presented
  always_comb begin
    end_addr  = {1'b0, in_req_address} + BLOCKS_EXT;
    range_err = (end_addr > SIZE_EXT);
    prot_err  = in_req_write && ({1'b0, in_req_address} < PROT_EXT);
    req_err   = range_err || prot_err;
  end

  // State register; reset abandons any in-flight request
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus the next values of the registered strobes
  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    load_req    = 1'b0;
    capture     = 1'b0;
    read_en_d   = 1'b0;
    write_en_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    case (state)
      IDLE: begin
        if (in_req_valid) begin
          accept = 1'b1;
          if (req_err) begin
            // Rejected: stay ready, answer next cycle, leave memory untouched
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else if (in_req_write) begin
            load_req   = 1'b1;
            write_en_d = 1'b1;
            next_state = WR_ISSUE;
          end else begin
            load_req   = 1'b1;
            read_en_d  = 1'b1;
            next_state = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        // Memory registers its output at the end of this cycle
        next_state = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        // Memory output is valid only now; sample it and respond
        capture     = 1'b1;
        rsp_valid_d = 1'b1;
        next_state  = IDLE;
      end
      WR_ISSUE: begin
        // Memory has written at the edge entering this state: acknowledge
        rsp_valid_d = 1'b1;
        next_state  = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Registered strobes toward memory and core; reset drops them at once
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      out_mem_read_en  <= 1'b0;
      out_mem_write_en <= 1'b0;
      out_rsp_valid    <= 1'b0;
      out_rsp_error    <= 1'b0;
    end else begin
      out_mem_read_en  <= read_en_d;
      out_mem_write_en <= write_en_d;
      out_rsp_valid    <= rsp_valid_d;
      out_rsp_error    <= rsp_error_d;
    end
  end

  // Address and write data latched on an accepted, legal request
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      out_mem_address <= '0;
      out_mem_data    <= '0;
    end else if (load_req) begin
      out_mem_address <= in_req_address;
      out_mem_data    <= in_req_data;
    end
  end

  // Read data capture; memory output is ignored outside RD_CAPTURE
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      out_rsp_data <= '0;
    end else if (capture) begin
      out_rsp_data <= in_mem_data;
    end
  end

  // Status forwarding, one cycle of latency, independent of the FSM
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      out_mem_write_status_en <= 1'b0;
      out_mem_status          <= '0;
    end else begin
      out_mem_write_status_en <= in_status_we;
      if (in_status_we) begin
        out_mem_status <= in_status;
      end
    end
  end

  logic unused_accept;
  assign unused_accept = accept;

endmodule

// File: tb/tb_memory_port_ctrl.sv
// Bench for memory_port_ctrl: a behavioural memory device on the pin side,
// a reference model of memory contents and request rules, and a scoreboard
// monitor that checks strobes, responses and status forwarding as they occur.
module tb_memory_port_ctrl;

  localparam int SIZE   = 1024;
  localparam int BLOCKS = 4;
  localparam int LOG    = 10;
  localparam int CW     = 32;
  localparam int W      = BLOCKS * CW;

  typedef struct {
    int           cyc;
    logic         err;
    logic [W-1:0] data;
  } rsp_t;

  typedef struct {
    int             cyc;
    logic [LOG-1:0] addr;
    logic [W-1:0]   data;
  } stb_t;

  typedef struct {
    string        name;
    logic [W-1:0] act;
    logic [W-1:0] exp;
  } chk_t;

  logic           in_clk = 1'b0;
  logic           in_reset = 1'b1;
  logic           in_req_valid = 1'b0;
  logic           in_req_write = 1'b0;
  logic [LOG-1:0] in_req_address = '0;
  logic [W-1:0]   in_req_data = '0;
  logic [CW-1:0]  in_status = '0;
  logic           in_status_we = 1'b0;
  logic           out_req_ready;
  logic           out_rsp_valid;
  logic [W-1:0]   out_rsp_data;
  logic           out_rsp_error;
  logic [LOG-1:0] out_mem_address;
  logic [W-1:0]   out_mem_data;
  logic           out_mem_read_en;
  logic           out_mem_write_en;
  logic [CW-1:0]  out_mem_status;
  logic           out_mem_write_status_en;
  logic [W-1:0]   in_mem_data;

  memory_port_ctrl dut (
    .in_clk                  (in_clk),
    .in_reset                (in_reset),
    .in_req_valid            (in_req_valid),
    .out_req_ready           (out_req_ready),
    .in_req_write            (in_req_write),
    .in_req_address          (in_req_address),
    .in_req_data             (in_req_data),
    .out_rsp_valid           (out_rsp_valid),
    .out_rsp_data            (out_rsp_data),
    .out_rsp_error           (out_rsp_error),
    .in_status               (in_status),
    .in_status_we            (in_status_we),
    .out_mem_address         (out_mem_address),
    .out_mem_data            (out_mem_data),
    .out_mem_read_en         (out_mem_read_en),
    .out_mem_write_en        (out_mem_write_en),
    .out_mem_status          (out_mem_status),
    .out_mem_write_status_en (out_mem_write_status_en),
    .in_mem_data             (in_mem_data)
  );

  always #5 in_clk = ~in_clk;

  int cycle = 0;
  always @(posedge in_clk) cycle <= cycle + 1;

  function automatic logic [CW-1:0] cell_init(int i);
    if (i >= 8 && i <= 11) return 32'(i - 7) * 32'h11;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Memory device: registered read port, garbage on the data bus otherwise
  logic [CW-1:0] mem [SIZE];
  logic [W-1:0]  mem_q = '0;
  logic [W-1:0]  junk = '0;
  logic          mem_q_vld = 1'b0;
  logic          mem_loaded = 1'b0;

  always @(posedge in_clk) begin
    junk      <= {$urandom, $urandom, $urandom, $urandom};
    mem_q_vld <= out_mem_read_en;
    if (!mem_loaded) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= cell_init(i);
      mem_loaded <= 1'b1;
    end else begin
      if (out_mem_write_en)
        for (int i = 0; i < BLOCKS; i++)
          mem[(int'(out_mem_address) + i) % SIZE] <= out_mem_data[i*CW +: CW];
      if (out_mem_write_status_en) mem[1] <= out_mem_status;
      if (out_mem_read_en)
        for (int i = 0; i < BLOCKS; i++)
          mem_q[i*CW +: CW] <= mem[(int'(out_mem_address) + i) % SIZE];
    end
  end

  assign in_mem_data = mem_q_vld ? mem_q : junk;

  // Reference model state and scoreboard queues
  logic [CW-1:0] ref_mem [SIZE];
  logic [W-1:0]  last_read = '0;
  rsp_t          exp_q[$];
  stb_t          rd_q[$];
  stb_t          wr_q[$];
  stb_t          st_q[$];
  chk_t          dq[$];

  int checks = 0;
  int errors = 0;

  task automatic tally(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic post(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    dq.push_back(c);
  endtask

  // Monitor: every observation point is compared against the queued expectations
  always @(negedge in_clk) begin
    chk_t c;
    stb_t e;
    rsp_t r;
    while (dq.size() > 0) begin
      c = dq.pop_front();
      tally(c.name, c.act, c.exp);
    end
    if (!in_reset && mem_loaded) begin
      if (out_mem_read_en || out_mem_write_en)
        tally("strobe_exclusive", W'(out_mem_read_en & out_mem_write_en), '0);

      if (out_mem_read_en) begin
        if (rd_q.size() == 0) tally("rd_strobe_unexpected", W'(1), W'(0));
        else begin
          e = rd_q.pop_front();
          tally("rd_strobe_cycle", W'(cycle), W'(e.cyc));
          tally("rd_address", W'(out_mem_address), W'(e.addr));
        end
      end else if (rd_q.size() > 0 && rd_q[0].cyc < cycle) begin
        rd_q.delete(0);
        tally("rd_strobe_missing", W'(0), W'(1));
      end

      if (out_mem_write_en) begin
        if (wr_q.size() == 0) tally("wr_strobe_unexpected", W'(1), W'(0));
        else begin
          e = wr_q.pop_front();
          tally("wr_strobe_cycle", W'(cycle), W'(e.cyc));
          tally("wr_address", W'(out_mem_address), W'(e.addr));
          tally("wr_data", out_mem_data, e.data);
        end
      end else if (wr_q.size() > 0 && wr_q[0].cyc < cycle) begin
        wr_q.delete(0);
        tally("wr_strobe_missing", W'(0), W'(1));
      end

      if (out_rsp_valid) begin
        if (exp_q.size() == 0) tally("rsp_unexpected", W'(1), W'(0));
        else begin
          r = exp_q.pop_front();
          tally("rsp_cycle", W'(cycle), W'(r.cyc));
          tally("rsp_error", W'(out_rsp_error), W'(r.err));
          tally("rsp_data", out_rsp_data, r.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cycle) begin
        exp_q.delete(0);
        tally("rsp_missing", W'(0), W'(1));
      end

      if (out_mem_write_status_en) begin
        if (st_q.size() == 0) tally("status_unexpected", W'(1), W'(0));
        else begin
          e = st_q.pop_front();
          tally("status_cycle", W'(cycle), W'(e.cyc));
          tally("status_value", W'(out_mem_status), e.data);
        end
      end else if (st_q.size() > 0 && st_q[0].cyc < cycle) begin
        st_q.delete(0);
        tally("status_missing", W'(0), W'(1));
      end
    end
  end

  // Present a request, wait (bounded) for acceptance, then queue expectations
  task automatic issue(input logic wr, input int addr, input logic [W-1:0] data,
                       input bit keep, input bit track, output int acc);
    logic         rdy;
    bit           err;
    logic [W-1:0] d;
    stb_t         s;
    rsp_t         r;
    acc = -1;
    in_req_valid   = 1'b1;
    in_req_write   = wr;
    in_req_address = LOG'(addr);
    in_req_data    = data;
    for (int i = 0; i < 50 && acc < 0; i++) begin
      rdy = out_req_ready;
      @(posedge in_clk);
      #1;
      if (rdy) acc = cycle;
    end
    if (!keep || acc < 0) in_req_valid = 1'b0;
    if (acc < 0) begin
      post("accept_timeout", W'(0), W'(1));
      return;
    end
    if (!track) return;
    err = (addr + BLOCKS > SIZE) || (wr && addr < 2);
    if (err) begin
      r = '{acc, 1'b1, last_read};
      exp_q.push_back(r);
    end else if (wr) begin
      for (int i = 0; i < BLOCKS; i++) ref_mem[addr + i] = data[i*CW +: CW];
      s = '{acc, LOG'(addr), data};
      wr_q.push_back(s);
      r = '{acc + 1, 1'b0, last_read};
      exp_q.push_back(r);
    end else begin
      for (int i = 0; i < BLOCKS; i++) d[i*CW +: CW] = ref_mem[addr + i];
      last_read = d;
      s = '{acc, LOG'(addr), '0};
      rd_q.push_back(s);
      r = '{acc + 2, 1'b0, d};
      exp_q.push_back(r);
    end
  endtask

  initial begin
    int   acc, acc0, acc1, acc2;
    int   a, pick;
    logic wr;
    stb_t s;

    for (int i = 0; i < SIZE; i++) ref_mem[i] = cell_init(i);

    // Reset state
    repeat (3) @(negedge in_clk);
    post("rst_ready", W'(out_req_ready), W'(1));
    post("rst_rsp_valid", W'(out_rsp_valid), '0);
    post("rst_rsp_error", W'(out_rsp_error), '0);
    post("rst_read_en", W'(out_mem_read_en), '0);
    post("rst_write_en", W'(out_mem_write_en), '0);
    post("rst_status_en", W'(out_mem_write_status_en), '0);
    post("rst_address", W'(out_mem_address), '0);
    post("rst_mem_data", out_mem_data, '0);
    post("rst_status", W'(out_mem_status), '0);
    post("rst_rsp_data", out_rsp_data, '0);
    in_reset = 1'b0;
    @(negedge in_clk);

    // Read of a known block at address 8
    issue(1'b0, 8, '0, 1'b0, 1'b1, acc);
    @(negedge in_clk);
    post("rd8_strobe_on", W'(out_mem_read_en), W'(1));
    @(negedge in_clk);
    post("rd8_strobe_off", W'(out_mem_read_en), '0);
    @(negedge in_clk);
    post("rd8_rsp_valid", W'(out_rsp_valid), W'(1));
    post("rd8_data", out_rsp_data, 128'h00000044_00000033_00000022_00000011);

    // Write at 4 then read it back
    issue(1'b1, 4, 128'h0000000D_0000000C_0000000B_0000000A, 1'b0, 1'b1, acc);
    @(negedge in_clk);
    post("wr4_strobe_on", W'(out_mem_write_en), W'(1));
    @(negedge in_clk);
    post("wr4_strobe_off", W'(out_mem_write_en), '0);
    post("wr4_ack", W'(out_rsp_valid), W'(1));
    issue(1'b0, 4, '0, 1'b0, 1'b1, acc);
    repeat (3) @(negedge in_clk);
    post("rd4_data", out_rsp_data, 128'h0000000D_0000000C_0000000B_0000000A);

    // Rejected requests and legal boundaries
    issue(1'b0, 1021, '0, 1'b0, 1'b1, acc);
    post("err_rd1021_ready", W'(out_req_ready), W'(1));
    post("err_rd1021_flag", W'(out_rsp_error), W'(1));
    issue(1'b1, 0, 128'h1, 1'b0, 1'b1, acc);
    post("err_wr0_ready", W'(out_req_ready), W'(1));
    issue(1'b1, 1, 128'h2, 1'b0, 1'b1, acc);
    post("err_wr1_ready", W'(out_req_ready), W'(1));
    post("err_wr1_flag", W'(out_rsp_error), W'(1));
    issue(1'b0, 1020, '0, 1'b0, 1'b1, acc);
    issue(1'b1, 2, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, acc);
    repeat (4) @(negedge in_clk);

    // Status update coinciding with a write accept
    in_status    = 32'hDEAD0001;
    in_status_we = 1'b1;
    issue(1'b1, 16, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, acc);
    in_status_we = 1'b0;
    s = '{acc, '0, W'(32'hDEAD0001)};
    st_q.push_back(s);
    ref_mem[1] = 32'hDEAD0001;
    @(negedge in_clk);
    post("coincident_write_en", W'(out_mem_write_en), W'(1));
    post("coincident_status_en", W'(out_mem_write_status_en), W'(1));
    @(negedge in_clk);
    post("status_held", W'(out_mem_status), W'(32'hDEAD0001));

    // Back-to-back status strobes
    in_status    = 32'h0000BEEF;
    in_status_we = 1'b1;
    @(posedge in_clk);
    #1;
    s = '{cycle, '0, W'(32'h0000BEEF)};
    st_q.push_back(s);
    in_status = 32'hCAFE0002;
    @(posedge in_clk);
    #1;
    s = '{cycle, '0, W'(32'hCAFE0002)};
    st_q.push_back(s);
    in_status_we = 1'b0;
    ref_mem[1] = 32'hCAFE0002;
    repeat (3) @(negedge in_clk);

    // Valid held continuously across three reads
    issue(1'b0, 8, '0, 1'b1, 1'b1, acc0);
    issue(1'b0, 100, '0, 1'b1, 1'b1, acc1);
    issue(1'b0, 200, '0, 1'b0, 1'b1, acc2);
    post("stream_gap1", W'(acc1 - acc0), W'(3));
    post("stream_gap2", W'(acc2 - acc1), W'(3));
    repeat (4) @(negedge in_clk);

    // Randomized traffic with boundary-weighted addresses
    for (int n = 0; n < 60; n++) begin
      wr   = 1'($urandom_range(0, 1));
      pick = int'($urandom_range(0, 9));
      case (pick)
        0:       a = int'($urandom_range(0, 1));
        1:       a = int'($urandom_range(1019, 1023));
        default: a = int'($urandom_range(2, 1018));
      endcase
      issue(wr, a, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, acc);
      repeat ($urandom_range(0, 2)) @(negedge in_clk);
    end
    repeat (4) @(negedge in_clk);

    // Reset while the read strobe is up: request is lost, no response
    issue(1'b0, 40, '0, 1'b0, 1'b0, acc);
    #1;
    in_reset = 1'b1;
    #1;
    post("midrst_read_en", W'(out_mem_read_en), '0);
    post("midrst_ready", W'(out_req_ready), W'(1));
    repeat (2) @(negedge in_clk);
    in_reset  = 1'b0;
    last_read = '0;
    post("midrst_rsp_data", out_rsp_data, '0);
    @(negedge in_clk);
    post("after_rst_ready", W'(out_req_ready), W'(1));
    repeat (5) @(negedge in_clk);
    issue(1'b0, 8, '0, 1'b0, 1'b1, acc);

    // Drain and confirm nothing is left outstanding
    repeat (6) @(negedge in_clk);
    post("pending_rsp", W'(exp_q.size()), '0);
    post("pending_rd", W'(rd_q.size()), '0);
    post("pending_wr", W'(wr_q.size()), '0);
    post("pending_status", W'(st_q.size()), '0);
    repeat (2) @(negedge in_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_port_ctrl.md
# memory_port_ctrl

Initiator side of the coprocessor's block memory port: accepts single-block read/write requests from the core over a valid/ready handshake and drives the memory's `in_address`/`in_data`/`in_read_en`/`in_write_en` pins with correct timing. It captures the registered `out_data` one cycle after the read strobe and returns it with a response pulse. It also forwards status-word updates to the memory's status-write port. It rejects out-of-range block accesses and block writes into the config/status words (cells 0 and 1).

## Interface
Parameters:
- `size`, 1024: memory depth in cells.
- `blocks`, 4: cells per block transfer.
- `log_size`, 10: address width.
- `cell_width`, 32: bits per cell.
- `width`, blocks*cell_width: block data width.

Ports:
- `in_clk` input 1: single clock; all state updates on its rising edge.
- `in_reset` input 1: asynchronous, active-high reset.
- `in_req_valid` input 1: core request present.
- `out_req_ready` input-side handshake output 1: high exactly when the FSM is in IDLE.
- `in_req_write` input 1: 1 selects block write, 0 selects block read.
- `in_req_address` input log_size: first cell of the block.
- `in_req_data` input width: write data; cell i is at `[i*cell_width +: cell_width]`.
- `out_rsp_valid` output 1: one-cycle response pulse.
- `out_rsp_data` output width: read data; holds its last value otherwise.
- `out_rsp_error` output 1: qualifies `out_rsp_valid`; the request was rejected.
- `in_status` input cell_width: new status word.
- `in_status_we` input 1: status update strobe.
- `out_mem_address` output log_size: to memory `in_address`.
- `out_mem_data` output width: to memory `in_data`.
- `out_mem_read_en` output 1: to memory `in_read_en`.
- `out_mem_write_en` output 1: to memory `in_write_en`.
- `out_mem_status` output cell_width: to memory `in_status`.
- `out_mem_write_status_en` output 1: to memory `in_write_status_en`.
- `in_mem_data` input width: from memory `out_data`; may be Z when the read strobe is low.

## Operation
- FSM states: IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE.
- Accept condition: `in_req_valid & out_req_ready`.
  - The accept latches address, data and direction.
  - Requests presented outside IDLE are ignored and must be held by the core.
- Range check on accept: `in_req_address + blocks > size` is an error. Compute it in log_size+1 bits so there is no wrap-around.
- Write protection: a write with `in_req_address < 2` is an error.
- On error:
  - The FSM stays in IDLE.
  - No memory strobe is asserted.
  - `out_rsp_valid` and `out_rsp_error` pulse in the next cycle.
  - `out_rsp_data` is unchanged.
- Read path:
  - IDLE to RD_ISSUE: `out_mem_read_en` is 1 for exactly one cycle.
  - RD_ISSUE to RD_CAPTURE: `in_mem_data` is sampled at the end of this cycle into `out_rsp_data`.
  - RD_CAPTURE to IDLE: `out_rsp_valid` pulses with `out_rsp_error` = 0.
- Write path:
  - IDLE to WR_ISSUE: `out_mem_write_en` is 1 for exactly one cycle, with address and data stable.
  - WR_ISSUE to IDLE: the ack `out_rsp_valid` pulses.
- `in_mem_data` is sampled only in RD_CAPTURE; Z or X on it at any other time must not propagate.
- Status forwarding is independent of the FSM:
  - `in_status_we` is registered to `out_mem_write_status_en` one cycle later, together with `out_mem_status`.
  - Back-to-back strobes each forward.
  - A status update coinciding with a block write is legal, because write protection guarantees disjoint cells.
- Read strobe and write strobe are never high in the same cycle.

## Timing
- Request accepted at edge k:
  - Read: `out_mem_read_en` is high between edges k and k+1. Data is captured at edge k+2. `out_rsp_valid` is high between edges k+2 and k+3. The next accept is possible at edge k+3.
  - Write: `out_mem_write_en` is high between edges k and k+1. The memory writes at edge k+1. The ack is high between edges k+1 and k+2. The next accept is possible at edge k+2.
  - Error: the response is high between edges k and k+1. Because `out_req_ready` stays 1, the next accept is possible at edge k+1.
- Status path latency: 1 cycle.
- Reset values:
  - FSM state is IDLE, so `out_req_ready` = 1.
  - All strobes are 0: `out_rsp_valid`, `out_rsp_error`, `out_mem_read_en`, `out_mem_write_en`, `out_mem_write_status_en`.
  - `out_mem_address`, `out_mem_data`, `out_mem_status` and `out_rsp_data` are 0.
- Reset mid-transaction: strobes drop asynchronously, no response is issued, and the in-flight request is lost.

## Structure
- Shared package contents:
  - State encoding: 2-bit typedef with IDLE=0, RD_ISSUE=1, RD_CAPTURE=2, WR_ISSUE=3.
  - Parameter defaults, shared with the memory block.
  - Constant `PROTECTED_CELLS` = 2.
- Single flat module with no sub-module. The range/protection check is a small combinational block inside it.

## Test plan
- Read at address 8, with memory cells 8..11 holding 0x11, 0x22, 0x33, 0x44:
  - `out_mem_read_en` is high for 1 cycle.
  - `out_rsp_data` = 0x00000044_00000033_00000022_00000011 with the response 2 cycles after accept.
- Write at address 4 with data 0xA..D, then read at address 4:
  - The read returns the same data.
  - Write ack arrives 1 cycle after accept; `out_mem_write_en` is high for exactly 1 cycle.
- Error cases, each giving a 1-cycle response with error = 1, no memory strobe, and ready never dropping:
  - Read at address 1021.
  - Write at address 0.
  - Write at address 1.
- `in_status_we` with 0xDEAD0001 asserted in the same cycle as a write accept at address 16:
  - The status strobe and the write strobe are both high in the next cycle.
  - Afterwards `out_status` = 0xDEAD0001.
- Assert `in_reset` during RD_ISSUE:
  - `out_mem_read_en` goes to 0 immediately.
  - No `out_rsp_valid` follows.
  - `out_req_ready` = 1 after reset is released.
- Drive `in_req_valid` continuously with 3 reads:
  - Accepts occur every 3 cycles.
  - Responses arrive in order with correct data.
